// File: rtl/alu_pkg.sv
// Shared definitions for the round-robin ALU scheduler: opcodes, FSM states and the
// default operand width.
package alu_pkg;

    localparam int unsigned DwDefault = 8;

    typedef enum logic [3:0] {
        OpAdd  = 4'd0,
        OpSub  = 4'd1,
        OpInc  = 4'd2,
        OpDec  = 4'd3,
        OpMul  = 4'd4,
        OpDiv  = 4'd5,
        OpShl  = 4'd6,
        OpShr  = 4'd7,
        OpAnd  = 4'd8,
        OpOr   = 4'd9,
        OpNand = 4'd10,
        OpNor  = 4'd11,
        OpXor  = 4'd12,
        OpXnor = 4'd13,
        OpNot  = 4'd14,
        OpBuf  = 4'd15
    } opcode_e;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StExec = 2'd1,
        StResp = 2'd2
    } state_e;

endpackage

// File: rtl/alu_core.sv
// Purely combinational ALU. Arithmetic ops work on zero-extended operands modulo 2^(2*DW);
// logic ops work on DW bits with the upper half of the result cleared.
module alu_core
    import alu_pkg::*;
#(
    parameter int unsigned DW = DwDefault
) (
    input  logic [3:0]      op,
    input  logic [DW-1:0]   a,
    input  logic [DW-1:0]   b,
    output logic [2*DW-1:0] result,
    output logic            div0
);

    logic [2*DW-1:0] za;
    logic [2*DW-1:0] zb;
    logic [2*DW-1:0] one;
    logic [DW-1:0]   zero_hi;

    assign za      = {{DW{1'b0}}, a};
    assign zb      = {{DW{1'b0}}, b};
    assign one     = {{(2*DW-1){1'b0}}, 1'b1};
    assign zero_hi = '0;

    always_comb begin
        result = '0;
        div0   = 1'b0;
        unique case (op)
            OpAdd:  result = za + zb;
            OpSub:  result = za - zb;
            OpInc:  result = za + one;
            OpDec:  result = za - one;
            OpMul:  result = za * zb;
            OpDiv: begin
                if (b == '0) begin
                    result = '1;
                    div0   = 1'b1;
                end else begin
                    result = za / zb;
                end
            end
            OpShl:  result = za << 1;
            OpShr:  result = za >> 1;
            OpAnd:  result = {zero_hi, a & b};
            OpOr:   result = {zero_hi, a | b};
            OpNand: result = {zero_hi, ~(a & b)};
            OpNor:  result = {zero_hi, ~(a | b)};
            OpXor:  result = {zero_hi, a ^ b};
            OpXnor: result = {zero_hi, ~(a ^ b)};
            OpNot:  result = {zero_hi, ~a};
            OpBuf:  result = za;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/alu_rr_sched.sv
// Round-robin front end for a single shared ALU: accept one request, compute it in a
// registered stage, then hold the response until the consumer takes it.
module alu_rr_sched
    import alu_pkg::*;
#(
    parameter int unsigned DW = DwDefault
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req0_valid,
    output logic            req0_ready,
    input  logic [3:0]      req0_op,
    input  logic [DW-1:0]   req0_a,
    input  logic [DW-1:0]   req0_b,
    input  logic            req1_valid,
    output logic            req1_ready,
    input  logic [3:0]      req1_op,
    input  logic [DW-1:0]   req1_a,
    input  logic [DW-1:0]   req1_b,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic            rsp_id,
    output logic [2*DW-1:0] rsp_data,
    output logic            rsp_err
);

    state_e          state_q;
    logic            rr_ptr_q;
    logic [3:0]      op_q;
    logic [DW-1:0]   a_q;
    logic [DW-1:0]   b_q;
    logic            id_q;
    logic            rsp_valid_q;
    logic [2*DW-1:0] rsp_data_q;
    logic            rsp_err_q;

    logic            grant_any;
    logic            grant_id;
    logic [2*DW-1:0] alu_result;
    logic            alu_div0;

    // rr_ptr only breaks ties; a lone requester is always granted.
    always_comb begin
        grant_any = req0_valid | req1_valid;
        grant_id  = (req0_valid & req1_valid) ? rr_ptr_q : req1_valid;
    end

    // Gated by rst so no handshake is signalled on a cycle whose capture is discarded.
    assign req0_ready = (state_q == StIdle) && !rst && grant_any && !grant_id;
    assign req1_ready = (state_q == StIdle) && !rst && grant_any && grant_id;

    alu_core #(
        .DW(DW)
    ) u_alu_core (
        .op    (op_q),
        .a     (a_q),
        .b     (b_q),
        .result(alu_result),
        .div0  (alu_div0)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            rr_ptr_q    <= 1'b0;
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            id_q        <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (grant_any) begin
                        op_q    <= grant_id ? req1_op : req0_op;
                        a_q     <= grant_id ? req1_a  : req0_a;
                        b_q     <= grant_id ? req1_b  : req0_b;
                        id_q    <= grant_id;
                        state_q <= StExec;
                    end
                end
                StExec: begin
                    rsp_data_q  <= alu_result;
                    rsp_err_q   <= alu_div0;
                    rsp_valid_q <= 1'b1;
                    state_q     <= StResp;
                end
                StResp: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        rr_ptr_q    <= ~id_q;
                        state_q     <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = id_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;

endmodule
